// File: rtl/qsys_counter_bank_if.sv
// Host request/response bus of the queue-system counter bank.
// The host drives requests; the bank answers with one response each.
interface qsys_counter_bank_if #(
  parameter int COUNTER_WIDTH = 32,
  parameter int ID_WIDTH      = 18
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ID_WIDTH-1:0]      req_id;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [COUNTER_WIDTH-1:0] rsp_data;
  logic                     rsp_error;

  modport master (
    output req_valid,
    output req_id,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_error
  );

  modport slave (
    input  req_valid,
    input  req_id,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_error
  );
endinterface

// File: rtl/qsys_counter_bank.sv
// Per-queue drop-statistics counters with a host responder for
// READ, READ_AND_CLEAR and a one-queue-per-cycle CLEAR_ALL sweep.
module qsys_counter_bank #(
  parameter int NUM_QUEUES    = 64,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               inc_valid,
  input  logic [11:0]        inc_queue,
  input  logic [3:0]         inc_counter_type,
  qsys_counter_bank_if.slave host,
  output logic               clear_busy
);

  localparam int NC   = 5;
  localparam int NENT = NUM_QUEUES * NC;
  localparam int AW   = (NENT > 1) ? $clog2(NENT) : 1;
  localparam int QW   = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  localparam logic [12:0]              NQ   = 13'(NUM_QUEUES);
  localparam logic [3:0]               NCT  = 4'(NC);
  localparam logic [QW-1:0]            LAST = QW'(NUM_QUEUES - 1);
  localparam logic [COUNTER_WIDTH-1:0] CMAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] ONE  = COUNTER_WIDTH'(1);

  localparam logic [1:0] OP_READ_AND_CLEAR = 2'd1;
  localparam logic [1:0] OP_CLEAR_ALL      = 2'd2;
  localparam logic [1:0] OP_RSVD           = 2'd3;

  typedef struct packed {
    logic [1:0]  op_code;
    logic [11:0] queue;
    logic [3:0]  counter_type;
  } qsys_counter_id_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  function automatic logic [AW-1:0] addr_of(
    input logic [11:0] q,
    input logic [3:0]  t
  );
    return AW'(32'(q) * 32'(NC) + 32'(t));
  endfunction

  state_e                   state;
  state_e                   state_nx;
  logic [QW-1:0]            idx;
  logic [QW-1:0]            idx_nx;
  logic                     sweep_done;

  logic                     s1_valid;
  logic [11:0]              s1_queue;
  logic [3:0]               s1_type;
  logic [AW-1:0]            s1_addr;
  logic                     inc_legal;

  qsys_counter_id_t         id;
  logic                     req_ready;
  logic                     req_fire;
  logic                     q_ok;
  logic                     t_ok;
  logic                     req_err;
  logic                     is_clear;
  logic                     is_rac;
  logic                     rac_fire;
  logic                     clr_fire;
  logic [AW-1:0]            rd_addr;
  logic [COUNTER_WIDTH-1:0] rd_val;
  logic [COUNTER_WIDTH-1:0] rd_next;

  logic [COUNTER_WIDTH-1:0] cnt [NENT];

  assign id        = host.req_id;
  assign q_ok      = {1'b0, id.queue} < NQ;
  assign t_ok      = id.counter_type < NCT;
  assign inc_legal = inc_valid
                   && ({1'b0, inc_queue} < NQ)
                   && (inc_counter_type < NCT);

  assign req_ready = aresetn && (state == IDLE)
                   && (!host.rsp_valid || host.rsp_ready);
  assign host.req_ready = req_ready;
  assign req_fire  = host.req_valid && req_ready;
  assign rac_fire  = req_fire && is_rac && !req_err;
  assign clr_fire  = req_fire && is_clear;
  assign clear_busy = (state == CLEAR);

  always_comb begin
    req_err  = 1'b0;
    is_clear = 1'b0;
    is_rac   = 1'b0;
    unique case (1'b1)
      id.op_code == OP_RSVD:      req_err = 1'b1;
      id.op_code == OP_CLEAR_ALL: is_clear = 1'b1;
      default: begin
        req_err = !(q_ok && t_ok);
        is_rac  = (id.op_code == OP_READ_AND_CLEAR);
      end
    endcase
  end

  // Out-of-range ids are steered to entry 0; their data is never used.
  assign rd_addr = (q_ok && t_ok) ? addr_of(id.queue, id.counter_type) : '0;
  assign rd_val  = cnt[rd_addr];
  assign s1_addr = addr_of(s1_queue, s1_type);

  // A read sees the stage-2 increment committing on its own edge.
  always_comb begin
    rd_next = rd_val;
    if (s1_valid && (s1_addr == rd_addr) && (rd_val != CMAX)) begin
      rd_next = rd_val + ONE;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid <= 1'b0;
      s1_queue <= '0;
      s1_type  <= '0;
    end else begin
      s1_valid <= inc_legal;
      s1_queue <= inc_queue;
      s1_type  <= inc_counter_type;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    sweep_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_fire) begin
          state_nx = CLEAR;
          idx_nx   = '0;
        end
      end
      CLEAR: begin
        if (idx == LAST) begin
          state_nx   = IDLE;
          idx_nx     = '0;
          sweep_done = 1'b1;
        end else begin
          idx_nx = idx + QW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  for (genvar g = 0; g < NENT; g++) begin : g_cnt
    localparam logic [AW-1:0] A = AW'(g);
    localparam logic [QW-1:0] Q = QW'(g / NC);
    logic [COUNTER_WIDTH-1:0] c;

    // Sweep clear beats a same-cycle increment to the queue being cleared.
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        c <= '0;
      end else if ((state == CLEAR) && (idx == Q)) begin
        c <= '0;
      end else if (rac_fire && (rd_addr == A)) begin
        c <= '0;
      end else if (s1_valid && (s1_addr == A) && (c != CMAX)) begin
        c <= c + ONE;
      end
    end

    assign cnt[g] = c;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
      host.rsp_error <= 1'b0;
    end else if (sweep_done) begin
      host.rsp_valid <= 1'b1;
      host.rsp_data  <= '0;
      host.rsp_error <= 1'b0;
    end else if (req_fire && !(is_clear && !req_err)) begin
      host.rsp_valid <= 1'b1;
      host.rsp_data  <= req_err ? '0 : rd_next;
      host.rsp_error <= req_err;
    end else if (host.rsp_ready) begin
      host.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qsys_counter_bank.sv
// Randomized bench for qsys_counter_bank against an array model,
// plus a narrow-counter instance for saturation.
module tb_qsys_counter_bank;
  localparam int NQ = 64;
  localparam int NC = 5;
  localparam int W  = 32;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic        inc_valid;
  logic [11:0] inc_queue;
  logic [3:0]  inc_counter_type;
  logic        clear_busy;

  qsys_counter_bank_if #(.COUNTER_WIDTH(W)) host ();

  qsys_counter_bank #(
    .NUM_QUEUES(NQ),
    .COUNTER_WIDTH(W)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .inc_valid(inc_valid),
    .inc_queue(inc_queue),
    .inc_counter_type(inc_counter_type),
    .host(host),
    .clear_busy(clear_busy)
  );

  logic        s_inc_valid;
  logic [11:0] s_inc_queue;
  logic [3:0]  s_inc_type;
  logic        s_clear_busy;

  qsys_counter_bank_if #(.COUNTER_WIDTH(3)) shost ();

  qsys_counter_bank #(
    .NUM_QUEUES(2),
    .COUNTER_WIDTH(3)
  ) sdut (
    .clk(clk),
    .aresetn(aresetn),
    .inc_valid(s_inc_valid),
    .inc_queue(s_inc_queue),
    .inc_counter_type(s_inc_type),
    .host(shost),
    .clear_busy(s_clear_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  longint unsigned mcnt [NQ][NC];
  bit              m_pend;
  int              m_pq;
  int              m_pt;
  bit              m_busy;
  int              m_idx;
  bit              m_rv;
  longint unsigned m_rd;
  bit              m_re;

  task automatic model_reset();
    for (int q = 0; q < NQ; q++)
      for (int t = 0; t < NC; t++)
        mcnt[q][t] = 0;
    m_pend = 0;
    m_busy = 0;
    m_idx  = 0;
    m_rv   = 0;
    m_rd   = 0;
    m_re   = 0;
  endtask

  function automatic logic [17:0] mk(input int op, input int q, input int t);
    logic [1:0]  o;
    logic [11:0] qq;
    logic [3:0]  tt;
    o  = 2'(op);
    qq = 12'(q);
    tt = 4'(t);
    return {o, qq, tt};
  endfunction

  task automatic step(input bit iv, input int iq, input int it,
                      input bit rv, input logic [17:0] rid, input bit rr);
    bit exp_ready;
    bit new_rsp;
    int op;
    int q;
    int t;
    bit err;
    inc_valid        = iv;
    inc_queue        = 12'(iq);
    inc_counter_type = 4'(it);
    host.req_valid   = rv;
    host.req_id      = rid;
    host.rsp_ready   = rr;
    #1;
    exp_ready = !m_busy && (!m_rv || rr);
    check("req_ready", host.req_ready, exp_ready);
    if (m_pend && mcnt[m_pq][m_pt] < MAXV) mcnt[m_pq][m_pt]++;
    new_rsp = 0;
    if (m_busy) begin
      for (int k = 0; k < NC; k++) mcnt[m_idx][k] = 0;
      if (m_idx == NQ - 1) begin
        m_busy  = 0;
        new_rsp = 1;
        m_rd    = 0;
        m_re    = 0;
      end else begin
        m_idx++;
      end
    end else if (rv && exp_ready) begin
      op  = int'(rid[17:16]);
      q   = int'(rid[15:4]);
      t   = int'(rid[3:0]);
      err = (op == 3) || (op != 2 && (q >= NQ || t >= NC));
      if (err) begin
        new_rsp = 1;
        m_rd    = 0;
        m_re    = 1;
      end else if (op == 2) begin
        m_busy = 1;
        m_idx  = 0;
      end else begin
        new_rsp = 1;
        m_rd    = mcnt[q][t];
        m_re    = 0;
        if (op == 1) mcnt[q][t] = 0;
      end
    end
    if (new_rsp) m_rv = 1;
    else if (rr) m_rv = 0;
    m_pend = iv && iq < NQ && it < NC;
    m_pq   = iq;
    m_pt   = it;
    @(posedge clk);
    @(negedge clk);
    check("rsp_valid", host.rsp_valid, m_rv);
    if (m_rv) begin
      check("rsp_data", host.rsp_data, m_rd);
      check("rsp_error", host.rsp_error, m_re);
    end
    check("clear_busy", clear_busy, m_busy);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, '0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rv"}, host.rsp_valid, 0);
    check({tag, "_rd"}, host.rsp_data, 0);
    check({tag, "_re"}, host.rsp_error, 0);
    check({tag, "_busy"}, clear_busy, 0);
    check({tag, "_ready"}, host.req_ready, 0);
  endtask

  initial begin
    int busy_n;
    int r;
    int iq;
    int op;
    bit iv;
    inc_valid = 0;
    inc_queue = '0;
    inc_counter_type = '0;
    host.req_valid = 0;
    host.req_id = '0;
    host.rsp_ready = 1;
    s_inc_valid = 0;
    s_inc_queue = '0;
    s_inc_type = '0;
    shost.req_valid = 0;
    shost.req_id = '0;
    shost.rsp_ready = 1;
    model_reset();
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    aresetn = 1;

    for (int k = 0; k < 10; k++) step(1, 3, 1, 0, '0, 1);
    step(0, 0, 0, 1, mk(0, 3, 1), 1);
    check("rd_q3t1", host.rsp_data, 10);
    step(0, 0, 0, 1, mk(0, 3, 1), 1);
    check("rd_q3t1_again", host.rsp_data, 10);

    for (int k = 0; k < 7; k++) step(1, 5, 0, 0, '0, 1);
    idle(1);
    step(1, 5, 0, 0, '0, 1);
    step(0, 0, 0, 1, mk(1, 5, 0), 1);
    check("rac_q5t0", host.rsp_data, 8);
    step(0, 0, 0, 1, mk(0, 5, 0), 1);
    check("rd_after_rac", host.rsp_data, 0);
    step(1, 5, 0, 0, '0, 1);
    idle(1);
    step(0, 0, 0, 1, mk(0, 5, 0), 1);
    check("rd_inc_after_rac", host.rsp_data, 1);

    step(1, 100, 1, 1, mk(3, 3, 1), 1);
    check("err_op3", host.rsp_error, 1);
    step(1, 3, 7, 1, mk(0, 64, 1), 1);
    check("err_q64", host.rsp_error, 1);
    step(0, 0, 0, 1, mk(1, 3, 5), 1);
    check("err_t5", host.rsp_error, 1);
    step(0, 0, 0, 1, mk(0, 3, 1), 1);
    check("rd_after_err", host.rsp_data, 10);

    step(0, 0, 0, 1, mk(0, 3, 1), 0);
    for (int k = 0; k < 5; k++) step(1, 3, 1, 1, mk(0, 5, 0), 0);
    check("hold_data", host.rsp_data, 10);
    step(0, 0, 0, 0, '0, 1);

    for (int k = 0; k < 3000; k++) begin
      r  = int'($urandom_range(0, 15));
      iq = (r < 12) ? int'($urandom_range(0, 7)) :
           (r == 12) ? 63 : (r == 13) ? 64 :
           (r == 14) ? 100 : int'($urandom_range(0, 63));
      iv = $urandom_range(0, 1) == 1;
      r  = int'($urandom_range(0, 99));
      op = (r < 2) ? 2 : (r < 6) ? 3 : int'($urandom_range(0, 1));
      step(iv, iq, int'($urandom_range(0, 6)),
           $urandom_range(0, 2) != 0,
           mk(op, int'($urandom_range(0, 8)), int'($urandom_range(0, 5))),
           $urandom_range(0, 3) != 0);
    end
    idle(70);

    for (int k = 0; k < 4; k++) step(1, 63, 0, 0, '0, 1);
    step(1, 0, 2, 0, '0, 1);
    step(0, 0, 0, 1, mk(2, 9, 9), 1);
    busy_n = int'(clear_busy);
    for (int k = 1; k <= 80; k++) begin
      if (host.rsp_valid) break;
      if (k == 3) step(1, 0, 2, 0, '0, 1);
      else if (k == 9) step(1, 63, 0, 0, '0, 1);
      else step(0, 0, 0, 0, '0, 1);
      busy_n += int'(clear_busy);
    end
    check("clr_busy_cycles", 64'(busy_n), 64);
    check("clr_rsp_valid", host.rsp_valid, 1);
    check("clr_rsp_data", host.rsp_data, 0);
    step(0, 0, 0, 1, mk(0, 0, 2), 1);
    check("clr_q0_inc", host.rsp_data, 1);
    step(0, 0, 0, 1, mk(0, 63, 0), 1);
    check("clr_q63_lost", host.rsp_data, 0);
    for (int q = 0; q < NQ; q++)
      for (int t = 0; t < NC; t++)
        step(0, 0, 0, 1, mk(0, q, t), 1);
    idle(1);

    for (int k = 0; k < 9; k++) begin
      s_inc_valid = 1;
      s_inc_queue = 12'd1;
      s_inc_type  = 4'd4;
      @(negedge clk);
    end
    s_inc_valid = 0;
    @(negedge clk);
    shost.req_valid = 1;
    shost.req_id = mk(0, 1, 4);
    @(negedge clk);
    check("sat_valid", shost.rsp_valid, 1);
    check("sat_data", shost.rsp_data, 7);
    check("sat_err", shost.rsp_error, 0);
    shost.req_id = mk(0, 2, 0);
    @(negedge clk);
    check("sat_q2_err", shost.rsp_error, 1);
    check("sat_q2_data", shost.rsp_data, 0);
    shost.req_valid = 0;
    @(negedge clk);

    step(1, 1, 1, 0, '0, 1);
    step(0, 0, 0, 1, mk(2, 0, 0), 1);
    idle(20);
    #2;
    aresetn = 0;
    #1;
    check_reset_outputs("mid_clear_reset");
    model_reset();
    inc_valid = 0;
    host.req_valid = 0;
    repeat (2) @(negedge clk);
    aresetn = 1;
    idle(70);
    step(0, 0, 0, 1, mk(0, 1, 1), 1);
    check("post_reset_cnt", host.rsp_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
